pc_gen: RTL
===========

Name: pc_gen

Overview:
- Program-counter register stage that consumes the branch-control decision (npc_mux_sel, pc_offset, reg_offset) and produces the fetch PC for the next cycle.
- Owns the PC register, stall hold, wrong-path flush pulse, and single-level interrupt entry/return (saves EPC, vectors, restores on mret).
- Sits between branch control (upstream) and the instruction-fetch/IMEM address port (downstream).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INT_VECTOR, 32'h0000_1C00, handler entry address for interrupts and the 2'b11 mux code.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- npc_mux_sel  in  2  00 PLUS4, 01 PC_OFFSET, 10 REG_OFFSET, 11 INTERRUPT.
- pc_offset  in  32  pc+imm branch/jal target.
- reg_offset  in  32  sr1+imm jalr target.
- stall  in  1  hazard hold; PC and state frozen.
- int_req  in  1  level interrupt request.
- mret  in  1  return-from-handler strobe (1 cycle).
- pc  out  32  current fetch PC.
- pc_valid  out  1  pc is a real fetch address.
- flush  out  1  kill the in-flight fetch/decode instruction (1-cycle pulse).
- int_ack  out  1  interrupt accepted (1-cycle pulse).
- epc  out  32  saved return PC.
- in_handler  out  1  high while in the handler.

Behaviour:
- Reset (async, rstn=0): pc=RESET_PC, pc_valid=0, flush=0, int_ack=0, epc=0, in_handler=0, state=RUN. rstn deassertion mid-operation discards all state; no pending interrupt is remembered.
- pc_valid goes to 1 on the first rising edge with rstn=1 and stays 1. pc is not advanced on that edge (first fetch is RESET_PC).
- Target computation, combinational:
  - PLUS4: pc+4.
  - PC_OFFSET: pc_offset.
  - REG_OFFSET: {reg_offset[31:1],1'b0}.
  - 11: INT_VECTOR.
  - All additions wrap modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
- States:
  - RUN: normal sequencing.
  - HANDLER: interrupt being serviced; in_handler=1.
- Per edge, when pc_valid=1 and stall=0:
  - RUN, int_req=0: pc <= target. flush <= 1 iff npc_mux_sel != 00.
  - RUN, int_req=1, or npc_mux_sel=11: epc <= target (a branch taken in the same cycle is preserved as the return point). pc <= INT_VECTOR, flush <= 1, int_ack <= 1, state <= HANDLER.
  - HANDLER, mret=1: pc <= epc, flush <= 1, state <= RUN.
  - HANDLER, mret=0: pc <= target. int_req is ignored (no nesting).
  - RUN, mret=1: mret is ignored.
- stall=1: pc, epc and state hold. flush and int_ack are forced to 0. int_req and mret are not latched; they must be presented again after the stall.
- flush and int_ack are registered, and are high for exactly one cycle after the triggering edge.
- Latency: the target presented in cycle N appears on pc in cycle N+1.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: if the selected PC_OFFSET or REG_OFFSET target has bits[1:0] != 0 while in RUN, the stage traps instead of jumping: epc <= pc (the faulting instruction), pc <= INT_VECTOR, flush=1, int_ack=1, state HANDLER. An added output misalign pulses 1 cycle alongside int_ack.
- Not defined: target bits[1:0] are forced to 00, no trap is taken, and the misalign port is absent.

Test Plan:
- Reset release with stall=0, sel=00 -> pc=0 for two cycles (pc_valid rises after the first), then 4, 8, 12; flush stays 0.
- pc=0x40, sel=01, pc_offset=0x100 -> next pc=0x100, flush=1 for one cycle, then pc=0x104.
- sel=10, reg_offset=0x2001 -> pc=0x2000. Without MISALIGN_TRAP_EN, reg_offset=0x2002 -> pc=0x2000. With the macro -> pc=0x1C00, epc=faulting pc, misalign=1.
- pc=0x80, int_req=1, sel=01, pc_offset=0x300 -> pc=0x1C00, epc=0x300, int_ack=1; a further int_req while in HANDLER is ignored; mret -> pc=0x300, flush=1, in_handler=0.
- stall=1 for 3 cycles with sel=01 and int_req=1 -> pc, epc and state unchanged, flush=int_ack=0. Releasing stall -> the interrupt is taken.
- rstn=0 asserted asynchronously while in HANDLER with pc=0x1C08 -> pc=RESET_PC, in_handler=0 and epc=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter stage: computes the next fetch PC, holds on stall, and handles one level of interrupt entry and return.
// Optional build macro MISALIGN_TRAP_EN traps misaligned branch/jalr targets and adds the misalign pulse output.
module pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_1C00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  npc_mux_sel,
    input  logic [31:0] pc_offset,
    input  logic [31:0] reg_offset,
    input  logic        stall,
    input  logic        int_req,
    input  logic        mret,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        int_ack,
    output logic [31:0] epc,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        in_handler
);

    typedef enum logic [1:0] {
        SEL_PLUS4  = 2'b00,
        SEL_PC_OFF = 2'b01,
        SEL_REG_OFF= 2'b10,
        SEL_INT    = 2'b11
    } sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic        pc_valid_q;
    logic        flush_q;
    logic        int_ack_q;
    sel_e        sel;
    logic [31:0] raw_target;
    logic [31:0] target;

    assign sel = sel_e'(npc_mux_sel);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        raw_target = pc_q + 32'd4;
        case (sel)
            SEL_PLUS4:   raw_target = pc_q + 32'd4;
            SEL_PC_OFF:  raw_target = pc_offset;
            SEL_REG_OFF: raw_target = reg_offset & 32'hFFFF_FFFE;
            SEL_INT:     raw_target = INT_VECTOR;
            default:     raw_target = pc_q + 32'd4;
        endcase
        target = raw_target & 32'hFFFF_FFFC;
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_hit;
    logic misalign_q;

    assign misalign_hit = (state_q == RUN) && ((sel == SEL_PC_OFF) || (sel == SEL_REG_OFF))
                          && (raw_target[1:0] != 2'b00);
    assign misalign = misalign_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            epc_q      <= 32'h0;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            int_ack_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            // Pulses default low; only a non-stalled triggering edge raises them.
            flush_q   <= 1'b0;
            int_ack_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            if (!pc_valid_q) begin
                pc_valid_q <= 1'b1;
            end else if (!stall) begin
                case (state_q)
                    RUN: begin
`ifdef MISALIGN_TRAP_EN
                        if (misalign_hit) begin
                            epc_q      <= pc_q;
                            pc_q       <= INT_VECTOR;
                            flush_q    <= 1'b1;
                            int_ack_q  <= 1'b1;
                            misalign_q <= 1'b1;
                            state_q    <= HANDLER;
                        end else
`endif
                        if (int_req || (sel == SEL_INT)) begin
                            epc_q     <= target;
                            pc_q      <= INT_VECTOR;
                            flush_q   <= 1'b1;
                            int_ack_q <= 1'b1;
                            state_q   <= HANDLER;
                        end else begin
                            pc_q    <= target;
                            flush_q <= (sel != SEL_PLUS4);
                        end
                    end
                    HANDLER: begin
                        if (mret) begin
                            pc_q    <= epc_q;
                            flush_q <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            pc_q    <= target;
                            flush_q <= (sel != SEL_PLUS4);
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign flush      = flush_q;
    assign int_ack    = int_ack_q;
    assign epc        = epc_q;
    assign in_handler = (state_q == HANDLER);

endmodule
